// File: rtl/adder_subtractor_pkg.sv
// Shared definitions for the adder/subtractor.
// Holds the operation-select encoding used on the `mode` input.
package adder_subtractor_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

endpackage

// File: rtl/adder_subtractor_full_adder.sv
// Single-bit full adder; one stage of the ripple-carry chain.
// Ports:
//   a, b  - operand bits
//   cin   - carry in
//   s     - sum bit
//   cout  - carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/adder_subtractor.sv
// Registered two's-complement adder/subtractor with signed-overflow flag.
// One cycle of latency, one operation per cycle, no enable.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset (clears result and ovfl)
//   a, b   - WIDTH-bit signed operands
//   mode   - 0 = a+b, 1 = a-b
//   result - registered sum/difference, modulo 2^WIDTH
//   ovfl   - registered signed-overflow flag for result
module adder_subtractor
    import adder_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic [WIDTH-1:0] result,
    output logic             ovfl
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   c;

    logic [WIDTH-1:0] result_d, result_q;
    logic             ovfl_d, ovfl_q;

    // Subtraction is a + ~b + 1: invert b and inject the +1 as carry-in.
    assign b_eff = b ^ {WIDTH{mode}};
    assign c[0]  = (mode == MODE_SUB);

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b_eff[i]),
            .cin  (c[i]),
            .s    (sum[i]),
            .cout (c[i+1])
        );
    end

    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_comb begin
        result_d = sum;
        ovfl_d   = c[WIDTH] ^ c[WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            ovfl_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            ovfl_q   <= ovfl_d;
        end
    end

    assign result = result_q;
    assign ovfl   = ovfl_q;

endmodule

// File: tb/tb_adder_subtractor.sv
module tb_adder_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic [WIDTH-1:0] result;
    logic             ovfl;

    int n_checks = 0;
    int n_fail   = 0;

    adder_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .mode   (mode),
        .result (result),
        .ovfl   (ovfl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact signed arithmetic, then wrap and range-check.
    function automatic void model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic m, output logic [WIDTH-1:0] r, output logic o);
        int sx;
        int sy;
        int t;
        sx = int'($signed(x));
        sy = int'($signed(y));
        t  = m ? (sx - sy) : (sx + sy);
        r  = t[WIDTH-1:0];
        o  = (t > 127) || (t < -128);
    endfunction

    task automatic check(input string tag, input logic [WIDTH-1:0] er, input logic eo);
        n_checks++;
        assert (result === er) else begin
            n_fail++;
            $error("FAIL %s result: got %h expected %h", tag, result, er);
        end
        n_checks++;
        assert (ovfl === eo) else begin
            n_fail++;
            $error("FAIL %s ovfl: got %b expected %b", tag, ovfl, eo);
        end
    endtask

    // Drive on the falling edge, check just after the next rising edge.
    task automatic step(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic m, input logic [WIDTH-1:0] er, input logic eo);
        @(negedge clk);
        a = x; b = y; mode = m;
        @(posedge clk);
        #1;
        check(tag, er, eo);
    endtask

    logic [WIDTH-1:0] exp_r;
    logic             exp_o;

    initial begin
        rst_n = 1'b0;
        a = 8'h6D; b = 8'h45; mode = 1'b0;
        #1;
        check("reset_immediate", 8'h00, 1'b0);
        #30;
        check("reset_held", 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", 8'hB2, 1'b1);

        // Each step occupies exactly one cycle: operands change every cycle.
        step("add_0_1",     8'h00, 8'h01, 1'b0, 8'h01, 1'b0);
        step("sub_0_1",     8'h00, 8'h01, 1'b1, 8'hFF, 1'b0);
        step("add_6_1",     8'h06, 8'h01, 1'b0, 8'h07, 1'b0);
        step("sub_6_1",     8'h06, 8'h01, 1'b1, 8'h05, 1'b0);
        step("add_01_F9",   8'h01, 8'hF9, 1'b0, 8'hFA, 1'b0);
        step("sub_01_F9",   8'h01, 8'hF9, 1'b1, 8'h08, 1'b0);
        step("add_F0_01",   8'hF0, 8'h01, 1'b0, 8'hF1, 1'b0);
        step("sub_F0_01",   8'hF0, 8'h01, 1'b1, 8'hEF, 1'b0);
        step("sub_01_81",   8'h01, 8'h81, 1'b1, 8'h80, 1'b1);
        step("add_01_81",   8'h01, 8'h81, 1'b0, 8'h82, 1'b0);
        step("add_80_9C",   8'h80, 8'h9C, 1'b0, 8'h1C, 1'b1);
        step("sub_80_9C",   8'h80, 8'h9C, 1'b1, 8'hE4, 1'b0);
        step("sub_85_21",   8'h85, 8'h21, 1'b1, 8'h64, 1'b1);
        step("add_85_21",   8'h85, 8'h21, 1'b0, 8'hA6, 1'b0);

        // Boundary extremes.
        step("add_7F_01",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b1);
        step("sub_80_01",   8'h80, 8'h01, 1'b1, 8'h7F, 1'b1);
        step("sub_00_80",   8'h00, 8'h80, 1'b1, 8'h80, 1'b1);
        step("sub_FF_80",   8'hFF, 8'h80, 1'b1, 8'h7F, 1'b0);

        // Reset mid-stream discards the in-flight operation.
        @(negedge clk);
        a = 8'h12; b = 8'h34; mode = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_async", 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check("midreset_held", 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_release", 8'h46, 1'b0);

        // Random back-to-back stream: at each falling edge the output must
        // reflect the vector driven one cycle earlier.
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (i > 0) check("random", exp_r, exp_o);
            a    = WIDTH'($urandom);
            b    = WIDTH'($urandom);
            mode = 1'($urandom);
            model(a, b, mode, exp_r, exp_o);
        end
        @(posedge clk);
        #1;
        check("random_last", exp_r, exp_o);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
